shared_dmem_responder: RTL
==========================

Name: shared_dmem_responder

Overview:
- Memory-side responder for the data-memory requests issued by the two PE pipelines (PE1, PE2) in the dual-core top.
- Accepts one load/store per cycle from either PE over a valid/ready handshake.
- Arbitrates round-robin into a single-ported word RAM and returns load data with fixed 1-cycle latency.
- Replaces the per-PE private data memories, so both PEs share one coherent data space.

Parameters:
- ADDR_W, 10, word-address width; RAM depth = 2**ADDR_W words.
- DATA_W, 32, data word width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid_pe1  in  1  PE1 request valid.
- req_we_pe1  in  1  PE1 request is store (1) or load (0).
- req_addr_pe1  in  32  PE1 byte address.
- req_wdata_pe1  in  DATA_W  PE1 store data.
- req_ready_pe1  out  1  PE1 request accepted this cycle (combinational).
- rsp_valid_pe1  out  1  PE1 load data valid.
- rsp_rdata_pe1  out  DATA_W  PE1 load data.
- req_valid_pe2, req_we_pe2, req_addr_pe2, req_wdata_pe2, req_ready_pe2, rsp_valid_pe2, rsp_rdata_pe2: same as PE1, for PE2.
- err  out  1  sticky access-error flag; see Optional Feature.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rsp_valid_pe1/pe2=0, rsp_rdata_pe1/pe2=0, err=0.
  - last_grant=PE2, so PE1 wins the first conflict.
  - RAM contents are not reset.
  - While rst=1: req_ready_pe1/pe2=0.
- Handshake:
  - A request transfers when req_valid && req_ready.
  - The PE holds valid, we, addr and wdata stable until ready.
  - ready never depends on a request's own we/addr.
- Arbitration, one grant per cycle:
  - Only one PE valid: that PE is granted.
  - Both valid: the PE not equal to last_grant is granted.
  - last_grant updates only on a transfer; it is unchanged on idle cycles.
  - Any waiting requester is therefore granted within 1 cycle of contention.
- Addressing:
  - Word index = addr[ADDR_W+1:2].
  - Without MEM_ERR_CHECK_EN: addr[1:0] is ignored and addr[31:ADDR_W+2] aliases (wrap-around).
- Store: RAM[index] <= wdata at the accepting edge. No response is generated.
- Load:
  - RAM is read at the accepting edge.
  - rsp_valid_peX=1 exactly one cycle after the transfer, for exactly one cycle.
  - rsp_rdata_peX holds the read word and retains its value when rsp_valid=0.
  - The other PE's response outputs are unaffected.
- Back-to-back:
  - A PE may issue a new request every cycle it is granted.
  - A load after a store to the same word, by either PE, returns the new data. Accesses are serialized, so no bypass is needed.
- No simultaneous-access hazard exists, because only one access reaches the RAM per cycle.
- Reset mid-operation: a load accepted in the cycle before rst rises produces no response. A store is committed if its edge precedes reset.

Optional Feature:
- Macro: MEM_ERR_CHECK_EN.
- Defined: a request is an error if addr[1:0] != 0 or addr[31:ADDR_W+2] != 0.
  - An erroring request is still accepted and still consumes its arbitration slot.
  - An erroring store is suppressed.
  - An erroring load returns rsp_valid=1 with rdata=0.
  - err is set on the accepting edge and stays 1 until reset.
- Undefined: no checks are made, err is tied to 0, and the addressing aliasing rule above applies.

Test Plan:
- PE1 stores 0xDEADBEEF to 0x10; next cycle PE1 loads 0x10 -> req_ready_pe1=1 both cycles; rsp_valid_pe1=1 one cycle after the load with rdata 0xDEADBEEF; rsp_valid_pe2 stays 0.
- After reset, both PEs load 0x0 and 0x4 and hold valid -> PE1 is granted in cycle 0 and PE2 in cycle 1; responses arrive in cycles 1 and 2 on the matching port.
- Both PEs hold valid for 6 cycles -> grants alternate PE1, PE2, PE1, …; each PE receives exactly 3 grants.
- PE2 stores 0x12345678 to 0x40 while PE1 loads 0x40 in the same cycle (PE2 has priority by last_grant) -> PE1 is granted the next cycle and receives 0x12345678.
- Assert rst the cycle after a PE1 load is accepted -> rsp_valid_pe1 stays 0; all outputs are 0 after reset; the RAM word at that address keeps its prior value.
- MEM_ERR_CHECK_EN defined: PE1 stores to 0x2 -> err=1 the next cycle and stays 1; a load of 0x0 does not return the stored data. Address 0x1000 with ADDR_W=10 also sets err, and a load of it returns 0.

Source files
------------

// File: rtl/shared_dmem_responder.sv
// Shared data-memory responder: round-robin arbitration of two PE request ports into one
// single-ported word RAM with 1-cycle load latency. Define MEM_ERR_CHECK_EN for address checks.
module shared_dmem_responder #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_pe1,
   input  logic              req_we_pe1,
   input  logic [31:0]       req_addr_pe1,
   input  logic [DATA_W-1:0] req_wdata_pe1,
   output logic              req_ready_pe1,
   output logic              rsp_valid_pe1,
   output logic [DATA_W-1:0] rsp_rdata_pe1,
   input  logic              req_valid_pe2,
   input  logic              req_we_pe2,
   input  logic [31:0]       req_addr_pe2,
   input  logic [DATA_W-1:0] req_wdata_pe2,
   output logic              req_ready_pe2,
   output logic              rsp_valid_pe2,
   output logic [DATA_W-1:0] rsp_rdata_pe2,
   output logic              err
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   logic              last_grant_q;  // 1: PE2 was granted last
   logic              grant_pe1, grant_pe2, xfer;
   logic              sel_we;
   logic [31:0]       sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [ADDR_W-1:0] sel_idx;
   logic              addr_err;
   logic              do_store;
   logic [DATA_W-1:0] load_data;
   logic              rsp_valid_pe1_q, rsp_valid_pe2_q;
   logic [DATA_W-1:0] rsp_rdata_pe1_q, rsp_rdata_pe2_q;

   always_comb begin
      grant_pe1 = 1'b0;
      grant_pe2 = 1'b0;
      if (!rst) begin
         if (req_valid_pe1 && (!req_valid_pe2 || last_grant_q)) begin
            grant_pe1 = 1'b1;
         end else if (req_valid_pe2) begin
            grant_pe2 = 1'b1;
         end
      end
   end

   assign xfer          = grant_pe1 | grant_pe2;
   assign req_ready_pe1 = grant_pe1;
   assign req_ready_pe2 = grant_pe2;

   assign sel_we    = grant_pe2 ? req_we_pe2    : req_we_pe1;
   assign sel_addr  = grant_pe2 ? req_addr_pe2  : req_addr_pe1;
   assign sel_wdata = grant_pe2 ? req_wdata_pe2 : req_wdata_pe1;
   assign sel_idx   = sel_addr[ADDR_W+1:2];

`ifdef MEM_ERR_CHECK_EN
   logic err_q;

   assign addr_err = (sel_addr[1:0] != 2'b00) || (|sel_addr[31:ADDR_W+2]);
   assign err      = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (xfer && addr_err) begin
         err_q <= 1'b1;
      end
   end
`else
   logic unused_addr_bits;

   // Unchecked build: low bits ignored and high bits alias onto the RAM.
   assign unused_addr_bits = ^{sel_addr[1:0], sel_addr[31:ADDR_W+2]};
   assign addr_err         = 1'b0;
   assign err              = 1'b0;
`endif

   assign do_store  = xfer && sel_we && !addr_err;
   assign load_data = addr_err ? '0 : mem[sel_idx];

   always_ff @(posedge clk) begin
      if (do_store) begin
         mem[sel_idx] <= sel_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q    <= 1'b1;
         rsp_valid_pe1_q <= 1'b0;
         rsp_valid_pe2_q <= 1'b0;
         rsp_rdata_pe1_q <= '0;
         rsp_rdata_pe2_q <= '0;
      end else begin
         rsp_valid_pe1_q <= grant_pe1 && !req_we_pe1;
         rsp_valid_pe2_q <= grant_pe2 && !req_we_pe2;
         if (grant_pe1 && !req_we_pe1) begin
            rsp_rdata_pe1_q <= load_data;
         end
         if (grant_pe2 && !req_we_pe2) begin
            rsp_rdata_pe2_q <= load_data;
         end
         if (xfer) begin
            last_grant_q <= grant_pe2;
         end
      end
   end

   // A load accepted just before reset must not surface while reset is asserted.
   assign rsp_valid_pe1 = rsp_valid_pe1_q && !rst;
   assign rsp_valid_pe2 = rsp_valid_pe2_q && !rst;
   assign rsp_rdata_pe1 = rsp_rdata_pe1_q;
   assign rsp_rdata_pe2 = rsp_rdata_pe2_q;

endmodule
